// File: rtl/fc_layer_stream_pkg.sv
// Shared types, weight table and arithmetic helpers for the streaming
// fully-connected layer. The weight table fixes the layer shape (N inputs,
// M outputs) and data width; the top-level parameters must agree with it.
package fc_layer_pkg;

   localparam int T_DEF = 8;   // data width, signed
   localparam int N_DEF = 4;   // inputs per vector
   localparam int M_DEF = 2;   // outputs per vector

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   typedef logic signed [T_DEF-1:0] data_t;
   typedef logic [$clog2(N_DEF)-1:0] n_idx_t;
   typedef logic [$clog2(M_DEF)-1:0] m_idx_t;

   // Accumulator wide enough that N full-scale products can never overflow.
   function automatic int acc_width(input int t, input int n);
      return 2 * t + $clog2(n);
   endfunction

   localparam int ACC_W = acc_width(T_DEF, N_DEF);
   typedef logic signed [ACC_W-1:0] acc_t;

   // Row m holds the weights applied to x[0..N-1] for output y[m].
   localparam data_t WEIGHTS [M_DEF][N_DEF] = '{
      '{ 8'sd1, 8'sd2,  8'sd3, 8'sd4},
      '{-8'sd1, 8'sd1, -8'sd1, 8'sd1}
   };

   function automatic data_t w(input m_idx_t m, input n_idx_t n);
      return WEIGHTS[m][n];
   endfunction

   localparam acc_t ACC_MAX = acc_t'(2 ** (T_DEF - 1) - 1);
   localparam acc_t ACC_MIN = acc_t'(-(2 ** (T_DEF - 1)));

   // Clamp the accumulator into the output range, then optionally zero
   // negative results.
   function automatic data_t sat_relu(input acc_t a, input logic relu);
      data_t r;
      if (a > ACC_MAX)
         r = {1'b0, {(T_DEF-1){1'b1}}};
      else if (a < ACC_MIN)
         r = {1'b1, {(T_DEF-1){1'b0}}};
      else
         r = a[T_DEF-1:0];
      if (relu && r[T_DEF-1])
         r = '0;
      return r;
   endfunction

endpackage

// File: rtl/fc_layer_stream_if.sv
// Valid/ready bundle for the layer: input words flow in on s_*, results
// flow out on m_*. The layer uses the slave view, the initiator the master.
interface fc_layer_stream_if #(
   parameter int T = 8
);
   logic                s_valid;
   logic                s_ready;
   logic signed [T-1:0] data_in;
   logic                m_valid;
   logic                m_ready;
   logic signed [T-1:0] data_out;

   modport slave (
      input  s_valid, data_in, m_ready,
      output s_ready, m_valid, data_out
   );

   modport master (
      output s_valid, data_in, m_ready,
      input  s_ready, m_valid, data_out
   );
endinterface

// File: rtl/fc_layer.sv
// The fc_layer_stream top level is defined in fc_layer_stream.sv.

// File: rtl/fc_layer_stream_mac.sv
// Signed multiply-accumulate. acc_next exposes the sum including the
// current product so the caller can capture the final result on the same
// edge that performs the last MAC.
module fc_mac
   import fc_layer_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  clr,
   input  logic  en,
   input  data_t a,
   input  data_t b,
   output acc_t  acc_next
);

   logic signed [2*T_DEF-1:0] prod;
   acc_t                      acc;

   assign prod     = a * b;
   assign acc_next = acc + acc_t'(prod);

   // Accumulator register: clear starts a new dot product, enable adds one term.
   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc_next;
   end

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: loads N inputs, runs M dot products at
// one MAC per cycle, saturates (and optionally rectifies) each result and
// presents it on a valid/ready output until taken.
module fc_layer_stream
   import fc_layer_pkg::*;
#(
   parameter int T    = T_DEF,
   parameter int N    = N_DEF,
   parameter int M    = M_DEF,
   parameter bit RELU = 1'b1
) (
   input logic              clk,
   input logic              reset_n,
   fc_layer_stream_if.slave bus
);

   localparam n_idx_t N_LAST = n_idx_t'(N - 1);
   localparam m_idx_t M_LAST = m_idx_t'(M - 1);

   state_t              state;
   state_t              state_nxt;
   n_idx_t              n_cnt;      // input index in LOAD, MAC term index in COMPUTE
   m_idx_t              m_cnt;      // output currently being computed/presented
   logic signed [T-1:0] x_mem [N];
   logic signed [T-1:0] data_q;
   logic                s_ready_c;
   logic                m_valid_c;
   logic                load_hs;
   logic                out_hs;
   logic                mac_clr;
   logic                mac_en;
   logic                n_last;
   logic                m_last;
   acc_t                acc_next;

   assign n_last = (n_cnt == N_LAST);
   assign m_last = (m_cnt == M_LAST);

   fc_mac u_mac (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (mac_clr),
      .en       (mac_en),
      .a        (w(m_cnt, n_cnt)),
      .b        (x_mem[n_cnt]),
      .acc_next (acc_next)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= LOAD;
      else
         state <= state_nxt;
   end

   // Next-state logic: LOAD until N words taken, N MAC cycles, then hold
   // the result until the consumer takes it.
   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:    if (load_hs && n_last) state_nxt = COMPUTE;
         COMPUTE: if (n_last)            state_nxt = OUTPUT;
         OUTPUT:  if (out_hs)            state_nxt = m_last ? LOAD : COMPUTE;
         default:                        state_nxt = LOAD;
      endcase
   end

   // Output decode: handshake flags come from registered state only.
   // NOTE: every signal written here gets a default first so no path
   // through the block leaves it unassigned and infers a latch.
   always_comb begin
      s_ready_c = 1'b0;
      m_valid_c = 1'b0;
      mac_en    = 1'b0;
      unique case (state)
         LOAD:    s_ready_c = 1'b1;
         COMPUTE: mac_en    = 1'b1;
         OUTPUT:  m_valid_c = 1'b1;
         default: ;
      endcase
      load_hs = s_ready_c && bus.s_valid;
      out_hs  = m_valid_c && bus.m_ready;
      mac_clr = (load_hs && n_last) || (out_hs && !m_last);
   end

   // Counters and output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_cnt  <= '0;
         m_cnt  <= '0;
         data_q <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (load_hs) begin
                  n_cnt <= n_last ? '0 : n_cnt + n_idx_t'(1);
                  if (n_last)
                     m_cnt <= '0;
               end
            end
            COMPUTE: begin
               n_cnt <= n_last ? '0 : n_cnt + n_idx_t'(1);
               if (n_last)
                  data_q <= sat_relu(acc_next, RELU);
            end
            OUTPUT: begin
               if (out_hs && !m_last)
                  m_cnt <= m_cnt + m_idx_t'(1);
            end
            default: ;
         endcase
      end
   end

   // Input vector storage, written only on an accepted word.
   // NOTE: x_mem has no reset; it is always fully rewritten before it is
   // read, so resetting it would only add logic.
   always_ff @(posedge clk) begin
      if (load_hs)
         x_mem[n_cnt] <= bus.data_in;
   end

   assign bus.s_ready  = s_ready_c;
   assign bus.m_valid  = m_valid_c;
   assign bus.data_out = data_q;

endmodule

// File: tb/tb_fc_layer_stream.sv
// Self-checking bench for fc_layer_stream. Two instances (RELU=1 and
// RELU=0) share the same stimulus; results are compared against a
// plain-arithmetic dot-product model.
module tb_fc_layer_stream;

   localparam int T = 8;
   localparam int N = 4;
   localparam int M = 2;

   logic                clk     = 1'b0;
   logic                reset_n = 1'b0;
   logic                s_valid = 1'b0;
   logic                m_ready = 1'b0;
   logic signed [T-1:0] data_in = '0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Observations captured by the stimulus tasks.
   logic signed [T-1:0] got_r [M];
   logic signed [T-1:0] got_n [M];
   int                  acc_edge;
   int                  valid_edge [M];
   int                  hs_edge [M];
   int                  bad_stable;
   int                  bad_sready;
   logic                timeout;
   logic                sready_after;

   int w_ref [M][N] = '{'{1, 2, 3, 4}, '{-1, 1, -1, 1}};

   fc_layer_stream_if #(.T(T)) bus_r ();
   fc_layer_stream_if #(.T(T)) bus_n ();

   assign bus_r.s_valid = s_valid;
   assign bus_r.data_in = data_in;
   assign bus_r.m_ready = m_ready;
   assign bus_n.s_valid = s_valid;
   assign bus_n.data_in = data_in;
   assign bus_n.m_ready = m_ready;

   fc_layer_stream #(.T(T), .N(N), .M(M), .RELU(1'b1)) dut_r (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_r)
   );

   fc_layer_stream #(.T(T), .N(N), .M(M), .RELU(1'b0)) dut_n (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int model_y(input int m, input int xv [N], input bit relu);
      int s = 0;
      for (int k = 0; k < N; k++) s += w_ref[m][k] * xv[k];
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   // Offer cnt words, with s_valid dropped pct% of cycles. Entered and left
   // at a falling edge; acc_edge is the edge count of the last accept.
   task automatic load_words(input int xv [N], input int cnt, input int pct);
      int   i     = 0;
      int   guard = 0;
      logic sr;
      while (i < cnt && guard < 1000) begin
         sr = bus_r.s_ready;
         if (int'($urandom_range(0, 99)) < pct) begin
            s_valid = 1'b0;
            data_in = 'x;
         end else begin
            s_valid = 1'b1;
            data_in = T'(xv[i]);
         end
         @(posedge clk);
         if (s_valid && sr) i++;
         @(negedge clk);
         guard++;
      end
      if (i < cnt) timeout = 1'b1;
      acc_edge = cyc;
      s_valid  = (cnt == N && pct == 0);
      data_in  = T'($urandom);
   endtask

   // One full vector: load, then collect M outputs with optional stalls.
   task automatic run_vector(input int xv [N], input int pct, input int mr_max, input bit hold0);
      int guard;
      int stall;
      bad_stable = 0;
      bad_sready = 0;
      timeout    = 1'b0;
      load_words(xv, N, pct);
      for (int m = 0; m < M; m++) begin
         guard = 0;
         while (bus_r.m_valid !== 1'b1 && guard < 1000 && !timeout) begin
            if (bus_r.s_ready !== 1'b0 || bus_n.s_ready !== 1'b0) bad_sready++;
            @(negedge clk);
            guard++;
         end
         if (bus_r.m_valid !== 1'b1) timeout = 1'b1;
         if (timeout) break;
         valid_edge[m] = cyc;
         got_r[m] = bus_r.data_out;
         got_n[m] = bus_n.data_out;
         stall = (hold0 && m == 0) ? 5 : int'($urandom_range(0, mr_max));
         m_ready = (stall == 0);
         repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_r.m_valid !== 1'b1 || bus_n.m_valid !== 1'b1 ||
                bus_r.data_out !== got_r[m] || bus_n.data_out !== got_n[m]) bad_stable++;
            if (bus_r.s_ready !== 1'b0 || bus_n.s_ready !== 1'b0) bad_sready++;
         end
         m_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         hs_edge[m] = cyc;
         m_ready = (mr_max == 0 && !hold0);
      end
      sready_after = bus_r.s_ready;
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_r.s_ready, bus_n.s_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_s_ready got=%b%b exp=11", bus_r.s_ready, bus_n.s_ready);
      end
      checks++;
      if ({bus_r.m_valid, bus_n.m_valid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_m_valid got=%b%b exp=00", bus_r.m_valid, bus_n.m_valid);
      end
      checks++;
      if (bus_r.data_out !== 8'sd0 || bus_n.data_out !== 8'sd0) begin
         errors++;
         $display("FAIL reset_data_out got=%0d/%0d exp=0", bus_r.data_out, bus_n.data_out);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_r.s_ready, bus_r.m_valid} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset_idle got=%b%b exp=10", bus_r.s_ready, bus_r.m_valid);
      end
   endtask

   task automatic test_basic();
      int xv [N] = '{1, 2, 3, 4};
      run_vector(xv, 0, 0, 1'b0);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL basic_timeout got=%b exp=0", timeout);
      end
      checks++;
      if (got_r[0] !== 8'sd30 || got_n[0] !== 8'sd30) begin
         errors++;
         $display("FAIL basic_y0 got=%0d/%0d exp=30", got_r[0], got_n[0]);
      end
      checks++;
      if (got_r[1] !== 8'sd2 || got_n[1] !== 8'sd2) begin
         errors++;
         $display("FAIL basic_y1 got=%0d/%0d exp=2", got_r[1], got_n[1]);
      end
      checks++;
      if (valid_edge[0] - acc_edge !== N) begin
         errors++;
         $display("FAIL first_latency got=%0d exp=%0d", valid_edge[0] - acc_edge, N);
      end
      checks++;
      if (valid_edge[1] - hs_edge[0] !== N) begin
         errors++;
         $display("FAIL next_latency got=%0d exp=%0d", valid_edge[1] - hs_edge[0], N);
      end
      checks++;
      if (sready_after !== 1'b1) begin
         errors++;
         $display("FAIL basic_s_ready_after got=%b exp=1", sready_after);
      end
   endtask

   task automatic test_saturation();
      int xin   [3][N] = '{'{127, 127, 127, 127}, '{4, 3, 2, 1}, '{-128, -128, -128, -128}};
      int exp_r [3][M] = '{'{127, 0}, '{20, 0}, '{0, 0}};
      int exp_n [3][M] = '{'{127, 0}, '{20, -2}, '{-128, 0}};
      int xv [N];
      for (int v = 0; v < 3; v++) begin
         xv = xin[v];
         run_vector(xv, 0, 0, 1'b0);
         checks++;
         if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL sat_timeout vec=%0d", v);
         end
         for (int m = 0; m < M; m++) begin
            checks++;
            if (got_r[m] !== T'(exp_r[v][m])) begin
               errors++;
               $display("FAIL sat_relu1 vec=%0d y%0d got=%0d exp=%0d", v, m, got_r[m], exp_r[v][m]);
            end
            checks++;
            if (got_n[m] !== T'(exp_n[v][m])) begin
               errors++;
               $display("FAIL sat_relu0 vec=%0d y%0d got=%0d exp=%0d", v, m, got_n[m], exp_n[v][m]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int xv [N] = '{1, 2, 3, 4};
      int prev_hs;
      logic [T-1:0] r8;
      run_vector(xv, 0, 0, 1'b0);
      prev_hs = hs_edge[M-1];
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < N; k++) begin
            r8 = T'($urandom);
            xv[k] = int'($signed(r8));
         end
         run_vector(xv, 0, 0, 1'b0);
         checks++;
         if (hs_edge[M-1] - prev_hs !== N + M * (N + 1)) begin
            errors++;
            $display("FAIL b2b_period got=%0d exp=%0d", hs_edge[M-1] - prev_hs, N + M * (N + 1));
         end
         for (int m = 0; m < M; m++) begin
            checks++;
            if (got_r[m] !== T'(model_y(m, xv, 1'b1)) || got_n[m] !== T'(model_y(m, xv, 1'b0))) begin
               errors++;
               $display("FAIL b2b_y%0d got=%0d/%0d exp=%0d/%0d", m, got_r[m], got_n[m],
                        model_y(m, xv, 1'b1), model_y(m, xv, 1'b0));
            end
         end
         prev_hs = hs_edge[M-1];
      end
      m_ready = 1'b0;
   endtask

   task automatic test_stall();
      int xv [N];
      int sel;
      logic [T-1:0] r8;
      for (int v = 0; v < 1000; v++) begin
         for (int k = 0; k < N; k++) begin
            r8  = T'($urandom);
            sel = int'($urandom_range(0, 7));
            xv[k] = (sel == 0) ? 127 : (sel == 1) ? -128 : int'($signed(r8));
         end
         run_vector(xv, 25, 3, (v % 10) == 0);
         checks++;
         if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout vec=%0d", v);
            break;
         end
         checks++;
         if (bad_stable !== 0) begin
            errors++;
            $display("FAIL stall_hold vec=%0d got=%0d unstable cycles exp=0", v, bad_stable);
         end
         checks++;
         if (bad_sready !== 0 || sready_after !== 1'b1) begin
            errors++;
            $display("FAIL stall_s_ready vec=%0d got=%0d early/%b after exp=0/1", v, bad_sready, sready_after);
         end
         for (int m = 0; m < M; m++) begin
            checks++;
            if (got_r[m] !== T'(model_y(m, xv, 1'b1)) || got_n[m] !== T'(model_y(m, xv, 1'b0))) begin
               errors++;
               $display("FAIL stall_y%0d vec=%0d got=%0d/%0d exp=%0d/%0d", m, v, got_r[m], got_n[m],
                        model_y(m, xv, 1'b1), model_y(m, xv, 1'b0));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int xp [N] = '{9, 9, 9, 9};
      int xo [N] = '{5, 6, 7, 8};
      int xv [N] = '{1, 2, 3, 4};
      int guard;
      for (int pass = 0; pass < 2; pass++) begin
         timeout = 1'b0;
         m_ready = 1'b0;
         if (pass == 0) begin
            load_words(xp, 2, 0);
         end else begin
            load_words(xo, N, 0);
            s_valid = 1'b0;
            guard = 0;
            while (bus_r.m_valid !== 1'b1 && guard < 20) begin
               @(negedge clk);
               guard++;
            end
            checks++;
            if (bus_r.m_valid !== 1'b1 || bus_r.data_out !== 8'sd70 || bus_n.data_out !== 8'sd70) begin
               errors++;
               $display("FAIL pre_reset_output got=%b/%0d/%0d exp=1/70/70", bus_r.m_valid,
                        bus_r.data_out, bus_n.data_out);
            end
         end
         s_valid = 1'b0;
         #2 reset_n = 1'b0;
         #1;
         checks++;
         if ({bus_r.s_ready, bus_n.s_ready, bus_r.m_valid, bus_n.m_valid} !== 4'b1100 ||
             bus_r.data_out !== 8'sd0 || bus_n.data_out !== 8'sd0) begin
            errors++;
            $display("FAIL async_reset pass=%0d got=%b%b%b%b/%0d/%0d exp=1100/0/0", pass,
                     bus_r.s_ready, bus_n.s_ready, bus_r.m_valid, bus_n.m_valid,
                     bus_r.data_out, bus_n.data_out);
         end
         @(negedge clk);
         reset_n = 1'b1;
         run_vector(xv, 0, 0, 1'b0);
         checks++;
         if (timeout !== 1'b0 || got_r[0] !== 8'sd30 || got_r[1] !== 8'sd2 ||
             got_n[0] !== 8'sd30 || got_n[1] !== 8'sd2) begin
            errors++;
            $display("FAIL after_reset pass=%0d got=%0d,%0d/%0d,%0d exp=30,2", pass,
                     got_r[0], got_r[1], got_n[0], got_n[1]);
         end
      end
      m_ready = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fc_layer_stream.md
# fc_layer_stream

Streaming fully-connected layer: receives an N-element signed input vector over a valid/ready slave port, computes M dot products against fixed weights with one multiply-accumulate per cycle, then saturates, optionally applies ReLU, and emits M signed results over a valid/ready master port. It is the computing endpoint behind the team's layer streaming benches. The bench is the initiator on both ports; this block is the responder.

## Interface
- T, 8: data width, signed two's complement on both ports.
- N, 4: inputs per vector.
- M, 2: outputs per vector.
- RELU, 1: 1 clamps negative results to 0 after saturation; 0 passes them through.
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is sampled on clk.
- s_valid  in  1  input word valid.
- m_ready  in  1  downstream ready.
- data_in  in  T  input word x[n], signed.
- m_valid  out  1  output word valid.
- s_ready  out  1  block accepts an input word.
- data_out  out  T  output word y[m], signed.

## Operation
- Three states.
  - LOAD: s_ready=1. Each s_valid&&s_ready edge writes x[n_cnt] and increments n_cnt. On the Nth accept, n_cnt goes to 0, m_cnt goes to 0, acc clears, and the state goes to COMPUTE.
  - COMPUTE: s_ready=0 and m_valid=0. Each cycle does acc += W[m_cnt][k]*x[k] for k=0..N-1, which takes N cycles. After the last MAC, data_out is loaded with post(acc) and the state goes to OUTPUT.
  - OUTPUT: m_valid=1 and data_out holds steady. On an m_valid&&m_ready edge:
    - if m_cnt<M-1: m_cnt++, acc clears, state goes to COMPUTE.
    - otherwise: state goes to LOAD.
- Arithmetic:
  - Products are 2T bits signed.
  - acc is 2T+$clog2(N) bits, so it never overflows.
  - post() saturates to [-2^(T-1), 2^(T-1)-1]. If RELU=1, a negative result then becomes 0.
- Weights are signed T-bit package constants. Defaults for N=4, M=2:
  - W[0] = {1,2,3,4}
  - W[1] = {-1,1,-1,1}
- Inputs are never dropped. s_ready is low outside LOAD, so the next vector waits upstream.
- Reset mid-operation discards any partial vector and any pending output. The block restarts in LOAD with n_cnt=m_cnt=0.
- A data_in value presented when s_valid=0 is ignored, including X.

## Timing
- Reset values:
  - state=LOAD, s_ready=1, m_valid=0, data_out=0.
  - acc=0, n_cnt=0, m_cnt=0.
  - x[] contents are don't-care.
- s_ready and m_valid are decoded from registered state only. They have no combinational path from s_valid or m_ready.
- First-output latency: with the Nth input accepted at edge k, m_valid rises after edge k+N. For the default N=4 that is edge k+4.
- Each subsequent output rises N cycles after the previous output handshake.
- Minimum period per vector is N + M·(N+1) cycles at full throughput. For the defaults that is 4+2·5 = 14 cycles.
- Once m_valid=1, data_out and m_valid stay stable until the handshake, for any number of m_ready-low cycles.
- Handshakes use only the values sampled at the rising edge. There are no simultaneous in/out handshakes, because the states are exclusive.

## Structure
- Package fc_layer_pkg holds:
  - the state enum typedef (LOAD, COMPUTE, OUTPUT);
  - the weight constant array and an accessor function w(m,n);
  - the accumulator width function;
  - the saturate/ReLU function sat_relu(acc, RELU).
- One sub-module, fc_mac: signed multiply plus accumulator register, with clear and enable inputs and async active-low reset.
- The top level owns the FSM, the x[] register file, the counters and the output register.

## Test plan
- x={1,2,3,4} with s_valid and m_ready held high: outputs 30 then 2. m_valid first rises 4 cycles after the 4th accept.
- x={127,127,127,127}: y0=1270 saturates to 127 (0x7F); y1=0.
- x={4,3,2,1}: y0=20. y1=-2 becomes 0 with RELU=1, and 0xFE with RELU=0.
- RELU=0, x={-128,-128,-128,-128}: y0=-1280 saturates to -128 (0x80); y1=0.
- Random s_valid/m_ready stalls over 1000 vectors, plus m_ready held low 5 cycles in OUTPUT:
  - data_out stable throughout the stall;
  - s_ready stays 0 until all M outputs are taken;
  - all results match the reference model.
- reset_n pulsed low after 2 of 4 inputs, and again mid-OUTPUT:
  - outputs go to reset values immediately, without waiting for a clk edge;
  - next vector {1,2,3,4} yields 30, 2.
